counter_cmd_ctrl: RTL and testbench
===================================

# counter_cmd_ctrl

Front-end command stage for the up/down counter selector system. It takes three raw push-button levels (up, down, complement) and turns them into the clean single-cycle `en`/`up_down`/`comp` command stream that the downstream up/down counter consumes. Each button is synchronized and debounced, then edge-detected. Up and down also auto-repeat while held, so one physical press yields exactly one counter step and a long hold yields a paced stream of steps.

## Interface
- `DB_CYCLES`, default 16: consecutive cycles a synchronized input must differ from its debounced state before the state flips; range ≥1.
- `HOLD_CYCLES`, default 50: cycles from the first step pulse to the first auto-repeat pulse; range ≥1.
- `RPT_CYCLES`, default 10: cycles between successive auto-repeat pulses; range ≥1.
- `clk` in, 1 bit: single clock, rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `btn_up` in, 1 bit: raw async level; 1 = pressed.
- `btn_down` in, 1 bit: raw async level; 1 = pressed.
- `btn_comp` in, 1 bit: raw async level; 1 = pressed.
- `en` out, 1 bit: one-cycle step-request pulse to the counter.
- `up_down` out, 1 bit: direction, 0 = up, 1 = down. Registered and held between pulses.
- `comp` out, 1 bit: one-cycle two's-complement request pulse to the counter.
- `busy` out, 1 bit: 1 while the FSM is not in IDLE.

## Operation
- **Synchronizer:** two flops per button (s1, s2). No logic sits between s1 and s2.
- **Debounce (per button):**
  - Each button has a counter of width clog2(DB_CYCLES)+1 and a debounced level `db`.
  - If s2 == db, the counter is cleared to 0.
  - If s2 != db and counter == DB_CYCLES-1, then `db` <= s2 and the counter is cleared.
  - Otherwise the counter increments.
- **Edge detect:** `ev_x` = `db_x` & ~`db_x_d`, where `db_x_d` is `db_x` delayed one cycle. Only rising edges produce events.
- **FSM states:** IDLE, HOLD, RPT. There is one timer, of width clog2(max(HOLD_CYCLES, RPT_CYCLES))+1.
- **IDLE:**
  - `ev_up` → `en`=1, `up_down`=0, active=UP, timer=HOLD_CYCLES-1, go to HOLD.
  - Else `ev_down` → same, with `up_down`=1 and active=DOWN.
  - If `ev_up` and `ev_down` occur in the same cycle, up wins.
- **HOLD:**
  - If the active `db` == 0, go to IDLE with no pulse.
  - Else if timer == 0, issue `en` with the held `up_down`, set timer=RPT_CYCLES-1, go to RPT.
  - Else decrement the timer.
- **RPT:**
  - Same release rule as HOLD.
  - On timer == 0, issue `en`, reload timer=RPT_CYCLES-1, stay in RPT.
- **Non-active buttons:** while in HOLD/RPT, up/down events from the non-active button are ignored.
  - A button that is still held after returning to IDLE does not fire, because it has no new rising edge.
- **Comp:**
  - `ev_comp` in any state → `comp`=1 for one cycle. There is no auto-repeat.
  - `comp` has priority over `en`. If a step pulse is due in the same cycle, `en` is suppressed, but the timer and state advance as if the pulse had been issued.
  - In IDLE, if `ev_comp` coincides with `ev_up`/`ev_down`, only `comp` fires and the FSM stays in IDLE.
- **Outputs:** `en` and `comp` are never high in the same cycle. All outputs are registered.

## Timing
- **Reset** (sync, `rst`=1 at a rising edge), applied to the next cycle:
  - `en`=0, `comp`=0, `up_down`=0, `busy`=0.
  - FSM=IDLE; all s1/s2/`db`/`db_d`=0; all counters and the timer = 0.
  - Reset asserted mid-HOLD/RPT aborts immediately and emits no pulse.
  - After release, a button held through reset produces a press event once it passes debounce.
- **Press latency:** raw rises before edge 1 and stays stable.
  - s2=1 after edge 2.
  - `db`=1 after edge 2+DB_CYCLES.
  - `en` is high in the cycle following edge 3+DB_CYCLES.
- **Release latency:** same arithmetic. `busy` falls one cycle after `db` falls.
- **Auto-repeat:** with the first `en` pulse at edge E, the next pulses are at E+HOLD_CYCLES, then +RPT_CYCLES each, for as long as `db` stays 1.
- **Bounce:** a glitch or bounce shorter than DB_CYCLES cycles at s2 never changes `db`.

## Test plan
All scenarios use `DB_CYCLES`=4, `HOLD_CYCLES`=8, `RPT_CYCLES`=3.
- **Reset:** hold `rst` 3 cycles with all buttons toggling → `en`/`comp`/`up_down`/`busy` all 0 while `rst`=1 and for the first cycle after release.
- **Single up press:** `btn_up` high from before edge 1 for 6 cycles → exactly one `en` pulse, in the cycle after edge 7, with `up_down`=0; `busy` returns to 0.
- **Down hold:** `btn_down` held 40 cycles → `en` pulses at edges 7, 15, 18, 21, … with `up_down`=1 throughout. Pulses stop within 7 cycles of release.
- **Bounce:** `btn_up` toggles every 2 cycles for 30 cycles and then stays low → zero `en` pulses and `busy` stays 0.
- **Comp during repeat:** up held, `btn_comp` timed so that `ev_comp` lands on a repeat edge → `comp`=1 and `en`=0 in that cycle, and the next `en` comes 3 cycles later.
- **Simultaneous press:** `btn_up` and `btn_down` rise together → the first pulse has `up_down`=0. Releasing up while down stays held → IDLE with no further pulses.

Source files
------------

// File: rtl/counter_cmd_ctrl.sv
// Push-button front end for the up/down counter: sync, debounce and edge-detect three buttons,
// then turn up/down presses into single or auto-repeating en pulses and comp presses into comp pulses.
module counter_cmd_ctrl #(
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 50,
  parameter int RPT_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_comp,
  output logic       en,
  output logic       up_down,
  output logic       comp,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam int DBW  = $clog2(DB_CYCLES) + 1;
  localparam int TMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
  localparam logic [TW-1:0]  HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]  RPT_LOAD  = TW'(RPT_CYCLES - 1);
  localparam logic [TW-1:0]  T_ONE     = TW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     raw;
  logic [2:0]     s1;
  logic [2:0]     s2;
  logic [2:0]     db;
  logic [2:0]     db_d;
  logic [2:0]     ev;
  logic [DBW-1:0] db_cnt [3];
  logic [TW-1:0]  timer;
  logic           active_down;
  logic           active_db;

  // Bit 0 = up, bit 1 = down, bit 2 = comp throughout.
  assign raw       = {btn_comp, btn_down, btn_up};
  assign ev        = db & ~db_d;
  assign active_db = active_down ? db[1] : db[0];
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // A comp event masks a due step pulse, but the timer and state still advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      active_down <= 1'b0;
      en          <= 1'b0;
      comp        <= 1'b0;
      up_down     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      en   <= 1'b0;
      comp <= ev[2];
      case (state)
        IDLE: begin
          if (!ev[2] && (ev[0] || ev[1])) begin
            en          <= 1'b1;
            up_down     <= !ev[0];
            active_down <= !ev[0];
            timer       <= HOLD_LOAD;
            state       <= HOLD;
            busy        <= 1'b1;
          end
        end
        HOLD, RPT: begin
          if (!active_db) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer == '0) begin
            en    <= !ev[2];
            timer <= RPT_LOAD;
            state <= RPT;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Directed bench for counter_cmd_ctrl with DB_CYCLES=4, HOLD_CYCLES=8, RPT_CYCLES=3.
// Loop index k names the clock edge at which the driven button levels are first sampled.
module tb_counter_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_comp;
  logic       en;
  logic       up_down;
  logic       comp;
  logic       busy;
  logic [1:0] fsm_state;

  int n_assert;
  int n_fail;

  counter_cmd_ctrl #(
    .DB_CYCLES  (4),
    .HOLD_CYCLES(8),
    .RPT_CYCLES (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_comp (btn_comp),
    .en       (en),
    .up_down  (up_down),
    .comp     (comp),
    .busy     (busy),
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp_v);
    end
  endtask

  task automatic drive(input logic u, input logic d, input logic c);
    btn_up   = u;
    btn_down = d;
    btn_comp = c;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Reset held three cycles with buttons toggling.
    for (int k = 1; k <= 3; k++) begin
      drive(k[0], !k[0], k[0]);
      tick();
      check("rst_en", k, en, 1'b0);
      check("rst_comp", k, comp, 1'b0);
      check("rst_up_down", k, up_down, 1'b0);
      check("rst_busy", k, busy, 1'b0);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("post_rst_en", 0, en, 1'b0);
    check("post_rst_comp", 0, comp, 1'b0);
    check("post_rst_up_down", 0, up_down, 1'b0);
    check("post_rst_busy", 0, busy, 1'b0);
    check("post_rst_state_idle", 0, fsm_state == 2'd0, 1'b1);

    // Single up press for 6 cycles: one en after edge 7, busy through edge 12.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      drive(k <= 6, 1'b0, 1'b0);
      tick();
      check("single_en", k, en, k == 7);
      check("single_busy", k, busy, (k >= 7) && (k <= 12));
      check("single_comp", k, comp, 1'b0);
      if (k == 7) check("single_up_down", k, up_down, 1'b0);
    end

    // Down held 40 cycles: en at 7, then 15, 18, ... up to 45; idle after edge 46.
    do_reset();
    for (int k = 1; k <= 55; k++) begin
      drive(1'b0, k <= 40, 1'b0);
      tick();
      check("down_en", k, en, (k == 7) || ((k >= 15) && (k <= 45) && ((k - 15) % 3 == 0)));
      check("down_busy", k, busy, (k >= 7) && (k <= 46));
      if (k >= 7) check("down_up_down", k, up_down, 1'b1);
    end

    // Bounce: up toggles every 2 cycles for 30 cycles, never long enough to debounce.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive((k <= 30) && (((k - 1) / 2) % 2 == 0), 1'b0, 1'b0);
      tick();
      check("bounce_en", k, en, 1'b0);
      check("bounce_busy", k, busy, 1'b0);
    end

    // Comp event lands on the repeat edge 18: comp wins, next en three cycles later.
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      drive(1'b1, 1'b0, (k >= 12) && (k <= 20));
      tick();
      check("comprpt_en", k, en, (k == 7) || (k == 15) || (k == 21) || (k == 24));
      check("comprpt_comp", k, comp, k == 18);
      check("comprpt_exclusive", k, en && comp, 1'b0);
    end

    // Up and down together: up wins; releasing up returns to idle with down still held.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive(k <= 12, 1'b1, 1'b0);
      tick();
      check("simul_en", k, en, (k == 7) || (k == 15) || (k == 18));
      check("simul_busy", k, busy, (k >= 7) && (k <= 18));
      if (k >= 7) check("simul_up_down", k, up_down, 1'b0);
    end

    // Reset asserted mid-HOLD aborts without a pulse.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    check("midrst_en", 11, en, 1'b0);
    check("midrst_busy", 11, busy, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
